// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared definitions for the UART receive controller.
//               The FSM state encoding is gray-coded so that each normal
//               transition flips one bit. Also provides the parity-type
//               constants and a 3-input majority helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    // Gray-coded receive states: IDLE->START->DATA->PARITY->STOP1->STOP2
    localparam logic [2:0] ST_IDLE   = 3'b000;
    localparam logic [2:0] ST_START  = 3'b001;
    localparam logic [2:0] ST_DATA   = 3'b011;
    localparam logic [2:0] ST_PARITY = 3'b010;
    localparam logic [2:0] ST_STOP1  = 3'b110;
    localparam logic [2:0] ST_STOP2  = 3'b111;

    // Parity type selector values
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Majority of three samples
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sampler
// Description : Per-bit timing for the UART receiver. Counts oversampling
//               edges 0..prescale-1 inside each bit, captures three samples
//               around mid-bit, votes them and flags the end of the bit.
// Ports       : CLK, RST        - clock, asynchronous active-low reset
//               i_rx            - synchronised serial line
//               i_prescale      - clocks per bit (frame-latched copy)
//               i_start         - start edge seen in IDLE; counter loads 1
//               i_run           - receiver is inside a frame
//               o_bit           - majority-voted bit value
//               o_end_bit       - last edge of the current bit
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      i_rx,
    input  logic [PRESCALE_WIDTH-1:0] i_prescale,
    input  logic                      i_start,
    input  logic                      i_run,
    output logic                      o_bit,
    output logic                      o_end_bit
);

    localparam logic [PRESCALE_WIDTH-1:0] C_ONE = PRESCALE_WIDTH'(1);

    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic                      s0_q, s0_d;
    logic                      s1_q, s1_d;
    logic                      s2_q, s2_d;
    logic [PRESCALE_WIDTH-1:0] w_half;

    assign w_half = i_prescale >> 1;

    always_comb begin
        s0_d       = s0_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        edge_cnt_d = edge_cnt_q;
        o_end_bit  = i_run && (edge_cnt_q == (i_prescale - C_ONE));

        if (i_run && (edge_cnt_q == (w_half - C_ONE))) s0_d = i_rx;
        if (i_run && (edge_cnt_q == w_half))           s1_d = i_rx;
        // With prescale=4 the third sample lands on the end-of-bit edge,
        // so the vote is taken from the next-state sample values.
        if (i_run && (edge_cnt_q == (w_half + C_ONE))) s2_d = i_rx;

        if (i_start) begin
            // The detection cycle already counted as edge 0
            edge_cnt_d = C_ONE;
        end else if (i_run) begin
            edge_cnt_d = o_end_bit ? '0 : (edge_cnt_q + C_ONE);
        end else begin
            edge_cnt_d = '0;
        end

        o_bit = maj3(s0_d, s1_d, s2_d);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_q <= '0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : UART receive controller. Frame FSM, LSB-first shift
//               register, parity/stop/break checks and registered one-cycle
//               result pulses. Bit timing lives in uart_rx_sampler.
// Ports       : CLK, RST        - oversampling clock, async active-low reset
//               RX_IN           - synchronised serial line, idle high
//               prescale        - clocks per bit
//               PAR_EN/PAR_TYP  - parity present / odd(1) or even(0)
//               STOP2           - two stop bits expected
//               P_DATA          - last good received word
//               data_valid, Parity_Error, Stop_Error, Break_Det - pulses
//               busy            - any state other than IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP2,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      Parity_Error,
    output logic                      Stop_Error,
    output logic                      Break_Det,
    output logic                      busy
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH);

    logic [2:0]                state_q, state_d;
    logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic                      stop2_q, stop2_d;
    logic                      all_zero_q, all_zero_d;
    logic                      stop_err_q, stop_err_d;
    logic                      par_bad_q, par_bad_d;
    logic                      brk_hold_q, brk_hold_d;
    logic                      dv_q, dv_d;
    logic                      perr_q, perr_d;
    logic                      serr_q, serr_d;
    logic                      brk_q, brk_d;

    logic w_bit;
    logic w_end;
    logic w_start;
    logic w_latch;
    logic w_frame_end;
    logic w_brk;
    logic w_perr_raw;

    uart_rx_sampler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_sampler (
        .CLK        (CLK),
        .RST        (RST),
        .i_rx       (RX_IN),
        .i_prescale (prescale_q),
        .i_start    (w_start),
        .i_run      (state_q != ST_IDLE),
        .o_bit      (w_bit),
        .o_end_bit  (w_end)
    );

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        p_data_d    = p_data_q;
        all_zero_d  = all_zero_q;
        stop_err_d  = stop_err_q;
        par_bad_d   = par_bad_q;
        brk_hold_d  = brk_hold_q;
        dv_d        = 1'b0;
        perr_d      = 1'b0;
        serr_d      = 1'b0;
        brk_d       = 1'b0;
        w_start     = 1'b0;
        w_latch     = 1'b0;
        w_frame_end = 1'b0;
        w_brk       = 1'b0;
        w_perr_raw  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // After a break the line is still low; wait for mark before
                // hunting for the next start bit so one break reports once.
                brk_hold_d = brk_hold_q & ~RX_IN;
                if (!RX_IN && !brk_hold_q) begin
                    state_d = ST_START;
                    w_start = 1'b1;
                    w_latch = 1'b1;
                end
            end
            ST_START: begin
                if (w_end) begin
                    if (w_bit) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_DATA;
                        bit_cnt_d  = '0;
                        all_zero_d = 1'b1;
                        stop_err_d = 1'b0;
                        par_bad_d  = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (w_end) begin
                    shift_d    = {w_bit, shift_q[DATA_WIDTH-1:1]};
                    all_zero_d = all_zero_q & ~w_bit;
                    if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? ST_PARITY : ST_STOP1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (w_end) begin
                    par_bad_d  = w_bit ^ (^shift_q) ^ (par_typ_q == PAR_ODD);
                    all_zero_d = all_zero_q & ~w_bit;
                    state_d    = ST_STOP1;
                end
            end
            ST_STOP1: begin
                if (w_end) begin
                    stop_err_d = stop_err_q | ~w_bit;
                    all_zero_d = all_zero_q & ~w_bit;
                    if (stop2_q) begin
                        state_d = ST_STOP2;
                    end else begin
                        w_frame_end = 1'b1;
                    end
                end
            end
            ST_STOP2: begin
                if (w_end) begin
                    stop_err_d  = stop_err_q | ~w_bit;
                    w_frame_end = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_frame_end) begin
            w_brk      = all_zero_d;
            w_perr_raw = par_en_q & par_bad_d;
            brk_d      = w_brk;
            perr_d     = w_perr_raw & ~w_brk;
            serr_d     = stop_err_d & ~w_brk;
            dv_d       = ~w_perr_raw & ~stop_err_d & ~w_brk;
            if (dv_d) begin
                p_data_d = shift_q;
            end
            if (w_brk) begin
                state_d    = ST_IDLE;
                brk_hold_d = 1'b1;
            end else if (!RX_IN) begin
                // Back-to-back frame; the sampler counter has just wrapped to 0
                state_d = ST_START;
                w_latch = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // Frame configuration is captured at frame start and held for the frame
    assign prescale_d = w_latch ? prescale : prescale_q;
    assign par_en_d   = w_latch ? PAR_EN   : par_en_q;
    assign par_typ_d  = w_latch ? PAR_TYP  : par_typ_q;
    assign stop2_d    = w_latch ? STOP2    : stop2_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            p_data_q   <= '0;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
            all_zero_q <= 1'b0;
            stop_err_q <= 1'b0;
            par_bad_q  <= 1'b0;
            brk_hold_q <= 1'b0;
            dv_q       <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            p_data_q   <= p_data_d;
            prescale_q <= prescale_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            stop2_q    <= stop2_d;
            all_zero_q <= all_zero_d;
            stop_err_q <= stop_err_d;
            par_bad_q  <= par_bad_d;
            brk_hold_q <= brk_hold_d;
            dv_q       <= dv_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            brk_q      <= brk_d;
        end
    end

    assign P_DATA       = p_data_q;
    assign data_valid   = dv_q;
    assign Parity_Error = perr_q;
    assign Stop_Error   = serr_q;
    assign Break_Det    = brk_q;
    assign busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Directed self-checking bench for uart_rx_ctrl. Frames are
//               driven bit by bit aligned to the clock; a negedge monitor
//               counts result pulses and records received words and the
//               cycle at which each data_valid appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       STOP2;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       Parity_Error;
    logic       Stop_Error;
    logic       Break_Det;
    logic       busy;

    uart_rx_ctrl #(
        .DATA_WIDTH     (8),
        .PRESCALE_WIDTH (6)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .prescale     (prescale),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .STOP2        (STOP2),
        .P_DATA       (P_DATA),
        .data_valid   (data_valid),
        .Parity_Error (Parity_Error),
        .Stop_Error   (Stop_Error),
        .Break_Det    (Break_Det),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Pulse monitor
    int         n_dv = 0;
    int         n_pe = 0;
    int         n_se = 0;
    int         n_bd = 0;
    logic [7:0] dv_hist [0:15];
    int         dv_at   [0:15];

    always @(negedge CLK) begin
        if (data_valid) begin
            dv_hist[n_dv % 16] = P_DATA;
            dv_at[n_dv % 16]   = cyc;
            n_dv++;
        end
        if (Parity_Error) n_pe++;
        if (Stop_Error)   n_se++;
        if (Break_Det)    n_bd++;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    int b_dv, b_pe, b_se, b_bd;
    task automatic snap();
        b_dv = n_dv;
        b_pe = n_pe;
        b_se = n_se;
        b_bd = n_bd;
    endtask

    task automatic drive_bit(input logic v, input int psc);
        RX_IN = v;
        repeat (psc) @(posedge CLK);
        #1;
    endtask

    // Caller is aligned 1ns after a rising edge; t0 is the cycle count then
    task automatic send_frame(input logic [7:0] d, input int psc, input bit par,
                              input bit pbit, input bit two_stop, input bit s1,
                              input bit s2, output int t0);
        t0 = cyc;
        drive_bit(1'b0, psc);
        for (int i = 0; i < 8; i++) drive_bit(d[i], psc);
        if (par) drive_bit(pbit, psc);
        drive_bit(s1, psc);
        if (two_stop) drive_bit(s2, psc);
        RX_IN = 1'b1;
    endtask

    int         t0a, t0b;
    logic [7:0] d81 = 8'h81;

    initial begin
        RST      = 1'b0;
        RX_IN    = 1'b1;
        prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        STOP2    = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_pdata", P_DATA, 8'h00);
        chk("rst_dv",    data_valid, 1'b0);
        chk("rst_pe",    Parity_Error, 1'b0);
        chk("rst_se",    Stop_Error, 1'b0);
        chk("rst_bd",    Break_Det, 1'b0);
        chk("rst_busy",  busy, 1'b0);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        // 0xA5, prescale 8, no parity, one stop: 80-cycle frame
        snap();
        send_frame(8'hA5, 8, 0, 0, 0, 1, 1, t0a);
        repeat (4) @(posedge CLK);
        #1;
        chk("a5_dv_cnt",  n_dv - b_dv, 1);
        chk("a5_data",    dv_hist[(n_dv - 1) % 16], 8'hA5);
        chk("a5_latency", dv_at[(n_dv - 1) % 16] - t0a, 80);
        chk("a5_errs",    (n_pe - b_pe) + (n_se - b_se) + (n_bd - b_bd), 0);
        chk("a5_pdata",   P_DATA, 8'hA5);
        chk("a5_busy",    busy, 1'b0);

        // Even parity, 0x3C with wrong parity bit 1
        prescale = 6'd16;
        PAR_EN   = 1'b1;
        PAR_TYP  = 1'b0;
        snap();
        send_frame(8'h3C, 16, 1, 1, 0, 1, 1, t0a);
        repeat (4) @(posedge CLK);
        #1;
        chk("par_pe_cnt", n_pe - b_pe, 1);
        chk("par_dv_cnt", n_dv - b_dv, 0);
        chk("par_se_bd",  (n_se - b_se) + (n_bd - b_bd), 0);
        chk("par_pdata",  P_DATA, 8'hA5);

        // Odd parity, 0x3C with correct parity bit 1
        PAR_TYP = 1'b1;
        snap();
        send_frame(8'h3C, 16, 1, 1, 0, 1, 1, t0a);
        repeat (4) @(posedge CLK);
        #1;
        chk("odd_dv_cnt", n_dv - b_dv, 1);
        chk("odd_pe_cnt", n_pe - b_pe, 0);
        chk("odd_pdata",  P_DATA, 8'h3C);

        // 2-cycle low glitch at prescale 8
        prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        snap();
        RX_IN = 1'b0;
        @(posedge CLK); #1;
        chk("gl_busy_e0", busy, 1'b1);
        @(posedge CLK); #1;
        RX_IN = 1'b1;
        repeat (5) @(posedge CLK); #1;
        chk("gl_busy_e6", busy, 1'b1);
        @(posedge CLK); #1;
        chk("gl_busy_e7", busy, 1'b0);
        repeat (10) @(posedge CLK); #1;
        chk("gl_pulses", (n_dv - b_dv) + (n_pe - b_pe) + (n_se - b_se) + (n_bd - b_bd), 0);
        chk("gl_busy_end", busy, 1'b0);

        // Two stop bits, second one low
        STOP2 = 1'b1;
        snap();
        send_frame(8'h55, 8, 0, 0, 1, 1, 0, t0a);
        repeat (20) @(posedge CLK);
        #1;
        chk("s2_se_cnt", n_se - b_se, 1);
        chk("s2_dv_cnt", n_dv - b_dv, 0);
        chk("s2_bd_cnt", n_bd - b_bd, 0);
        STOP2 = 1'b0;

        // Back-to-back frames, no idle gap
        snap();
        send_frame(8'h3C, 8, 0, 0, 0, 1, 1, t0a);
        send_frame(8'hC3, 8, 0, 0, 0, 1, 1, t0b);
        repeat (4) @(posedge CLK);
        #1;
        chk("b2b_dv_cnt", n_dv - b_dv, 2);
        chk("b2b_data0",  dv_hist[b_dv % 16], 8'h3C);
        chk("b2b_data1",  dv_hist[(b_dv + 1) % 16], 8'hC3);
        chk("b2b_gap",    dv_at[(b_dv + 1) % 16] - dv_at[b_dv % 16], 80);

        // Line break: 20 bit times low
        snap();
        drive_bit(1'b0, 160);
        RX_IN = 1'b1;
        repeat (20) @(posedge CLK);
        #1;
        chk("brk_bd_cnt", n_bd - b_bd, 1);
        chk("brk_se_cnt", n_se - b_se, 0);
        chk("brk_dv_cnt", n_dv - b_dv, 0);
        chk("brk_pdata",  P_DATA, 8'hC3);
        chk("brk_busy",   busy, 1'b0);

        // Reset during data bit 4 of 0x81
        drive_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) drive_bit(d81[i], 8);
        RX_IN = d81[4];
        repeat (3) @(posedge CLK);
        #1;
        chk("mid_busy", busy, 1'b1);
        RST = 1'b0;
        #1;
        chk("arst_pdata", P_DATA, 8'h00);
        chk("arst_busy",  busy, 1'b0);
        chk("arst_pulse", {data_valid, Parity_Error, Stop_Error, Break_Det}, 4'b0000);
        RX_IN = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        snap();
        repeat (30) @(posedge CLK);
        #1;
        chk("post_rst_quiet", (n_dv - b_dv) + (n_pe - b_pe) + (n_se - b_se) + (n_bd - b_bd), 0);
        send_frame(8'h81, 8, 0, 0, 0, 1, 1, t0a);
        repeat (4) @(posedge CLK);
        #1;
        chk("x81_dv_cnt", n_dv - b_dv, 1);
        chk("x81_pdata",  P_DATA, 8'h81);

        // Configuration changes mid-frame are ignored until the next frame
        snap();
        fork
            send_frame(8'h5A, 8, 0, 0, 0, 1, 1, t0a);
            begin
                repeat (20) @(posedge CLK);
                #2;
                prescale = 6'd5;
                PAR_EN   = 1'b1;
                PAR_TYP  = 1'b1;
                STOP2    = 1'b1;
            end
        join
        repeat (4) @(posedge CLK);
        #1;
        chk("cfg_dv_cnt",  n_dv - b_dv, 1);
        chk("cfg_data",    dv_hist[(n_dv - 1) % 16], 8'h5A);
        chk("cfg_latency", dv_at[(n_dv - 1) % 16] - t0a, 80);
        chk("cfg_errs",    (n_pe - b_pe) + (n_se - b_se) + (n_bd - b_bd), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
